// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-side memory arbiter: FSM state and owner encodings, default line size.
package mem_arb_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_I_FILL  = 3'd1,
    ST_D_FILL  = 3'd2,
    ST_D_WRITE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_line_counter.sv
// Line word counter: IDX_W+1 bits wide so it can reach LINE_WORDS, with synchronous
// clear, enable and a registered terminal-count flag (count == LINE_WORDS).
module line_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [IDX_W:0] cnt_o,
  output logic           tc_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tc_d = (cnt_d == CNT_W'(LINE_WORDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined single-port memory between I-cache fills and D-cache fills/writes.
// Build option ARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2 * LINE_WORDS - 1);

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~LINE_MASK;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic              i_fv_q, i_fv_d;
  logic              d_fv_q, d_fv_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
`ifdef ARB_RR_EN
  owner_e            last_owner_q, last_owner_d;
`endif

  logic              in_fill_c;
  logic              d_pick_c;
  logic              iss_clr_c, iss_en_c, ret_en_c;
  logic [CNT_W-1:0]  iss_cnt, ret_cnt;
  logic              iss_tc, ret_tc;

  // Counters are cleared while idle so every transaction starts at word 0.
  assign in_fill_c = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
  assign iss_clr_c = (state_q == ST_IDLE);
  assign iss_en_c  = in_fill_c && mem_en_q && !iss_tc;
  assign ret_en_c  = in_fill_c && mem_rvalid && !ret_tc;

  line_counter #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (iss_clr_c),
    .en_i  (iss_en_c),
    .cnt_o (iss_cnt),
    .tc_o  (iss_tc)
  );

  line_counter #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_return_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (iss_clr_c),
    .en_i  (ret_en_c),
    .cnt_o (ret_cnt),
    .tc_o  (ret_tc)
  );

  // Tie-break between simultaneous requests; a lone requester always wins.
  always_comb begin
`ifdef ARB_RR_EN
    d_pick_c = d_req && (!i_req || (last_owner_q == OWN_I));
`else
    d_pick_c = d_req;
`endif
  end

  // Next-state and registered-output computation; memory commands are staged one cycle ahead.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_data_d = fill_data_q;
    fill_idx_d  = fill_idx_q;
    i_fv_d      = 1'b0;
    d_fv_d      = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (d_pick_c) begin
`ifdef ARB_RR_EN
          last_owner_d = OWN_D;
`endif
          mem_en_d = 1'b1;
          if (d_wr) begin
            state_d     = ST_D_WRITE;
            base_d      = d_addr;
            mem_wr_d    = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d    = ST_D_FILL;
            base_d     = line_base(d_addr);
            mem_addr_d = line_base(d_addr);
          end
        end else if (i_req) begin
`ifdef ARB_RR_EN
          last_owner_d = OWN_I;
`endif
          state_d    = ST_I_FILL;
          base_d     = line_base(i_addr);
          mem_en_d   = 1'b1;
          mem_addr_d = line_base(i_addr);
        end
      end

      ST_I_FILL, ST_D_FILL: begin
        if (iss_en_c) begin
          mem_en_d = (iss_cnt != LAST_IDX);
          if (mem_en_d) begin
            mem_addr_d = base_q + (ADDR_W'(iss_cnt + CNT_W'(1)) << 1);
          end
        end
        if (ret_en_c) begin
          fill_data_d = mem_rdata;
          fill_idx_d  = IDX_W'(ret_cnt);
          if (state_q == ST_I_FILL) begin
            i_fv_d = 1'b1;
          end else begin
            d_fv_d = 1'b1;
          end
          if (ret_cnt == LAST_IDX) begin
            state_d  = ST_DONE;
            i_done_d = (state_q == ST_I_FILL);
            d_done_d = (state_q == ST_D_FILL);
          end
        end
      end

      ST_D_WRITE: begin
        state_d  = ST_DONE;
        d_done_d = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
      i_fv_q      <= 1'b0;
      d_fv_q      <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_data_q <= fill_data_d;
      fill_idx_q  <= fill_idx_d;
      i_fv_q      <= i_fv_d;
      d_fv_q      <= d_fv_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_RR_EN
  // Remembers the last winner; resets to I so the first tie goes to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_I;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign fill_data    = fill_data_q;
  assign fill_idx     = fill_idx_q;
  assign i_fill_valid = i_fv_q;
  assign d_fill_valid = d_fv_q;
  assign i_done       = i_done_q;
  assign d_done       = d_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and random transactions
// against a transaction-level expectation and a fixed-latency memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_done;
  logic        d_done;
  logic        busy;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .fill_data    (fill_data),
    .fill_idx     (fill_idx),
    .i_fill_valid (i_fill_valid),
    .d_fill_valid (d_fill_valid),
    .i_done       (i_done),
    .d_done       (d_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int unsigned lat = 4;

  function automatic logic [15:0] init_word(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  // Memory model: reads return lat cycles after issue, in order; writes land immediately.
  typedef struct packed {
    int          due;
    logic [15:0] data;
  } beat_t;

  beat_t       rq[$];
  logic [15:0] wmem[int];
  int          cyc = 0;

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      wmem[int'(mem_addr[15:1])] = mem_wdata;
    end else if (mem_en) begin
      rq.push_back('{due: cyc + int'(lat),
                     data: wmem.exists(int'(mem_addr[15:1])) ? wmem[int'(mem_addr[15:1])]
                                                            : init_word(int'(mem_addr[15:1]))});
    end
    cyc = cyc + 1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= rq[0].data;
      void'(rq.pop_front());
    end else begin
      mem_rvalid <= 1'b0;
    end
  end

  // Bench-side view of memory contents, updated only by the writes the bench requests.
  logic [15:0] shadow[int];

  function automatic logic [15:0] exp_word(input int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                i_fill_valid, d_fill_valid, i_done, d_done, busy});
  endfunction

  // One complete transaction from a single requester; cycle 0 is the idle cycle that sees req.
  task automatic run_txn(input string nm, input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int unsigned l,
                         input logic [15:0] exp_base, input int exp_done);
    int ncmd;
    int nbeat;
    int done_c;
    lat = l;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    ncmd = 0; nbeat = 0; done_c = -1;
    for (int c = 0; c < 64 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 0) check({nm, " idle"}, 64'({busy, mem_en}), 64'(0));
      if (c == 2) begin
        i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (mem_en) begin
        check($sformatf("%s cmd%0d addr", nm, ncmd), 64'(mem_addr), 64'(exp_base + 16'(2 * ncmd)));
        check($sformatf("%s cmd%0d wr", nm, ncmd), 64'(mem_wr), 64'(wr));
        check($sformatf("%s cmd%0d cycle", nm, ncmd), 64'(c), 64'(ncmd + 1));
        if (wr) check({nm, " wdata"}, 64'(mem_wdata), 64'(wdata));
        ncmd++;
      end
      if (i_fill_valid || d_fill_valid) begin
        check($sformatf("%s beat%0d side", nm, nbeat), 64'({i_fill_valid, d_fill_valid}),
              64'(is_d ? 2'b01 : 2'b10));
        check($sformatf("%s beat%0d idx", nm, nbeat), 64'(fill_idx), 64'(nbeat));
        check($sformatf("%s beat%0d data", nm, nbeat), 64'(fill_data),
              64'(exp_word(int'(exp_base[15:1]) + nbeat)));
        nbeat++;
      end
      if (i_done || d_done) begin
        done_c = c;
        check({nm, " done side"}, 64'({i_done, d_done}), 64'(is_d ? 2'b01 : 2'b10));
        check({nm, " done busy"}, 64'(busy), 64'(1));
      end
    end
    check({nm, " done cycle"}, 64'(done_c), 64'(exp_done));
    check({nm, " cmd count"}, 64'(ncmd), 64'(wr ? 1 : 8));
    check({nm, " beat count"}, 64'(nbeat), 64'(wr ? 0 : 8));
    if (wr) shadow[int'(addr[15:1])] = wdata;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    check({nm, " after done"}, 64'({busy, mem_en}), 64'(0));
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned lat;
    logic [15:0] exp_base;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          hit;
    bit          first_d;
    bit          exp_d;
    bit          got_d;
    int          nb_i;
    int          nb_d;
    int          seen;
    int          stale;
    bit          r_d;
    bit          r_wr;
    logic [15:0] r_addr;
    int unsigned r_lat;

    vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 4, 16'h1230, 13};
    vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 4, 16'h0040, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 2, 16'h00F0, 11};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 1, 16'hFFF0, 10};
    vecs[4] = '{1'b1, 1'b1, 16'h1234, 16'hCAFE, 3, 16'h1234, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h123B, 16'h0000, 3, 16'h1230, 12};

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset outputs", all_outs(), 64'(0));

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].lat, vecs[i].exp_base, vecs[i].exp_done);
    end

    // Simultaneous requests right after a D win.
    run_txn("pre-tie write", 1'b1, 1'b1, 16'h0100, 16'h1111, 2, 16'h0100, 2);
`ifdef ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    lat = 2;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h3004; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4008;
    for (int ph = 0; ph < 2; ph++) begin
      exp_d = (ph == 0) ? first_d : !first_d;
      nb_i = 0; nb_d = 0; seen = 0; got_d = 1'b0;
      for (int c = 0; c < 64 && seen == 0; c++) begin
        @(negedge clk);
        if (i_fill_valid) nb_i++;
        if (d_fill_valid) nb_d++;
        if (i_done || d_done) begin
          seen = 1;
          got_d = d_done;
        end
      end
      check($sformatf("tie ph%0d done seen", ph), 64'(seen), 64'(1));
      check($sformatf("tie ph%0d winner", ph), 64'(got_d), 64'(exp_d));
      check($sformatf("tie ph%0d winner beats", ph), 64'(exp_d ? nb_d : nb_i), 64'(8));
      check($sformatf("tie ph%0d loser beats", ph), 64'(exp_d ? nb_i : nb_d), 64'(0));
      @(posedge clk); #1;
      if (exp_d) d_req = 1'b0; else i_req = 1'b0;
    end
    @(negedge clk);
    check("tie idle", 64'({busy, mem_en}), 64'(0));

    // Reset while beat 3 of a fill is on the outputs.
    lat = 4;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h2000;
    hit = 1'b0;
    for (int c = 0; c < 64 && !hit; c++) begin
      @(negedge clk);
      if (i_fill_valid && fill_idx == 3'd3) hit = 1'b1;
    end
    check("reset beat3 reached", 64'(hit), 64'(1));
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    check("mid-fill reset outputs", all_outs(), 64'(0));
    @(negedge clk);
    check("held reset outputs", all_outs(), 64'(0));
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_fill_valid || d_fill_valid || busy || mem_en) stale++;
    end
    check("stale beats ignored", 64'(stale), 64'(0));
    run_txn("post-reset fill", 1'b0, 1'b0, 16'h2002, 16'h0000, 4, 16'h2000, 13);

    for (int i = 0; i < 20; i++) begin
      r_d    = 1'($urandom_range(0, 1));
      r_wr   = r_d ? 1'($urandom_range(0, 1)) : 1'b0;
      r_addr = 16'h5000 | 16'($urandom_range(0, 255));
      if (r_wr) r_addr[0] = 1'b0;
      r_lat  = $urandom_range(1, 5);
      run_txn($sformatf("rand%0d", i), r_d, r_wr, r_addr, 16'($urandom), r_lat,
              r_wr ? r_addr : (r_addr & 16'hFFF0), r_wr ? 2 : 9 + int'(r_lat));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
